// File: rtl/product_norm_pkg.sv
// Shared types and constants for the product carry normalizer.
// max_passes() is the bound on carry passes for an n-element product.
package product_norm_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      PROP = 2'd1,
      DONE = 2'd2
   } norm_state_t;

   function automatic int max_passes(input int n);
      return 2 * n + 1;
   endfunction

endpackage

// File: rtl/product_carry_normalizer_carry_pass.sv
// One parallel carry-propagation pass: each word keeps its low WORD_LEN bits
// and absorbs the carry bits of the word below it.
module carry_pass #(
   parameter int NUM_WORDS  = 66,
   parameter int WORD_LEN   = 16,
   parameter int IN_BIT_LEN = 17
) (
   input  logic [IN_BIT_LEN-1:0] words      [NUM_WORDS],
   output logic [IN_BIT_LEN-1:0] next_words [NUM_WORDS],
   output logic                  any_carry,
   output logic                  top_carry
);

   localparam int CARRY_BITS = IN_BIT_LEN - WORD_LEN;

   always_comb begin
      any_carry     = 1'b0;
      next_words[0] = {{CARRY_BITS{1'b0}}, words[0][WORD_LEN-1:0]};
      for (int i = 0; i < NUM_WORDS; i++) begin
         any_carry = any_carry | (|words[i][IN_BIT_LEN-1:WORD_LEN]);
      end
      // The width rule guarantees low word + carry always fits in IN_BIT_LEN.
      for (int i = 1; i < NUM_WORDS; i++) begin
         next_words[i] = {{CARRY_BITS{1'b0}}, words[i][WORD_LEN-1:0]}
                       + {{WORD_LEN{1'b0}}, words[i-1][IN_BIT_LEN-1:WORD_LEN]};
      end
      top_carry = |words[NUM_WORDS-1][IN_BIT_LEN-1:WORD_LEN];
   end

endmodule

// File: rtl/product_carry_normalizer.sv
// Iteratively ripples carry bits of the multiplier product words upward until
// every word is canonical, then hands the result over a valid/ready port.
module product_carry_normalizer
   import product_norm_pkg::*;
#(
   parameter int NUM_ELEMENTS = 33,
   parameter int WORD_LEN     = 16,
   parameter int IN_BIT_LEN   = 17,
   parameter int PASS_W       = $clog2(2 * NUM_ELEMENTS + 2)
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [IN_BIT_LEN-1:0] in_words  [2*NUM_ELEMENTS],
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [WORD_LEN-1:0]   out_words [2*NUM_ELEMENTS],
   output logic                  overflow,
   output logic [PASS_W-1:0]     pass_count,
   output norm_state_t           state_dbg
);

   // Handshake: a transfer happens on a posedge where valid && ready are both
   // high; ready/valid depend on the state register only, and data is held
   // stable from valid rising until the transfer edge.

   localparam int NUM_WORDS  = 2 * NUM_ELEMENTS;
   localparam int CARRY_BITS = IN_BIT_LEN - WORD_LEN;

   norm_state_t           state;
   logic [IN_BIT_LEN-1:0] work     [NUM_WORDS];
   logic [IN_BIT_LEN-1:0] nxt      [NUM_WORDS];
   logic                  any_carry;
   logic                  top_carry;

   carry_pass #(
      .NUM_WORDS  (NUM_WORDS),
      .WORD_LEN   (WORD_LEN),
      .IN_BIT_LEN (IN_BIT_LEN)
   ) u_pass (
      .words      (work),
      .next_words (nxt),
      .any_carry  (any_carry),
      .top_carry  (top_carry)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state      <= IDLE;
         overflow   <= 1'b0;
         pass_count <= '0;
         for (int i = 0; i < NUM_WORDS; i++) work[i] <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  for (int i = 0; i < NUM_WORDS; i++) work[i] <= in_words[i];
                  overflow   <= 1'b0;
                  pass_count <= '0;
                  state      <= PROP;
               end
            end
            PROP: begin
               if (any_carry) begin
                  for (int i = 0; i < NUM_WORDS; i++) work[i] <= nxt[i];
                  pass_count <= pass_count + PASS_W'(1);
                  overflow   <= overflow | top_carry;
               end else begin
                  state <= DONE;
               end
            end
            DONE: begin
               if (out_ready) state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   // A pass beyond the bound means the ripple argument is broken.
   always_ff @(posedge clk) begin
      if (rst_n && state == PROP && any_carry) begin
         assert (int'(pass_count) < max_passes(NUM_ELEMENTS));
      end
   end

   assign in_ready  = (state == IDLE);
   assign out_valid = (state == DONE);
   assign state_dbg = state;

   always_comb begin
      for (int i = 0; i < NUM_WORDS; i++) out_words[i] = work[i][WORD_LEN-1:0];
   end

   logic unused_carry_bits;
   assign unused_carry_bits = (CARRY_BITS == 0);

endmodule

// File: tb/tb_product_carry_normalizer.sv
// Directed and random scoreboard bench for product_carry_normalizer with four
// product words; expected results are hand-computed or summed arithmetically.
module tb_product_carry_normalizer;
   import product_norm_pkg::*;

   localparam int NE   = 2;
   localparam int NW   = 2 * NE;
   localparam int WL   = 16;
   localparam int IB   = 17;
   localparam int PW   = $clog2(2 * NE + 2);
   localparam int MAXP = max_passes(NE);
   localparam int EW   = 32 + 8 + 1 + 64;

   logic          clk;
   logic          rst_n;
   logic          in_valid;
   logic          in_ready;
   logic [IB-1:0] in_words  [NW];
   logic          out_valid;
   logic          out_ready;
   logic [WL-1:0] out_words [NW];
   logic          overflow;
   logic [PW-1:0] pass_count;
   norm_state_t   state_dbg;

   logic [EW-1:0] exp_q[$];
   int            checks = 0;
   int            fails  = 0;
   int            cyc    = 0;
   bit            rand_rdy = 0;
   logic [63:0]   outw;

   product_carry_normalizer #(
      .NUM_ELEMENTS (NE),
      .WORD_LEN     (WL),
      .IN_BIT_LEN   (IB)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_words   (in_words),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_words  (out_words),
      .overflow   (overflow),
      .pass_count (pass_count),
      .state_dbg  (state_dbg)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   always_comb outw = {out_words[3], out_words[2], out_words[1], out_words[0]};

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // driver: caller is aligned at posedge+#1; returns aligned at posedge+#1
   task automatic send(input logic [4*IB-1:0] v, input logic [63:0] ew, input logic eo,
                       input logic [7:0] ep, input bit push, output int acc);
      int n;
      for (int i = 0; i < NW; i++) in_words[i] = v[IB*i +: IB];
      in_valid = 1'b1;
      n = 0;
      @(negedge clk);
      while (!in_ready && n < 200) begin
         @(negedge clk);
         n++;
      end
      acc = -1;
      if (!in_ready) begin
         chk("accept_timeout", in_ready, 1);
         in_valid = 1'b0;
         @(posedge clk); #1;
      end else begin
         @(posedge clk); #1;
         in_valid = 1'b0;
         acc = cyc;
         if (push) exp_q.push_back({32'(cyc), ep, eo, ew});
      end
   endtask

   // scoreboard monitor
   logic [EW-1:0] item;
   logic          seen = 0;
   logic          prev_stall = 0;
   logic [63:0]   held_w;
   logic          held_o;
   logic [PW-1:0] held_p;

   always @(negedge clk) begin
      if (!rst_n) begin
         seen       = 0;
         prev_stall = 0;
      end else begin
         if (prev_stall) begin
            chk("stall_valid", out_valid, 1);
            chk("stall_words", outw, held_w);
            chk("stall_ovf", overflow, held_o);
            chk("stall_pass", pass_count, held_p);
         end
         prev_stall = 0;
         if (out_valid) begin
            chk("in_ready_in_done", in_ready, 0);
            if (!seen) begin
               seen = 1;
               if (exp_q.size() == 0) begin
                  chk("unexpected_output", exp_q.size(), 1);
               end else begin
                  item = exp_q[0];
                  chk("latency", 64'(cyc - int'(item[104:73])), 64'(pass_count) + 1);
                  if (item[72:65] != 8'hFF) chk("pass_count", pass_count, item[72:65]);
                  chk("pass_bound", (int'(pass_count) <= MAXP), 1);
               end
            end
            if (out_ready) begin
               if (exp_q.size() != 0) begin
                  item = exp_q.pop_front();
                  chk("out_words", outw, item[63:0]);
                  chk("overflow", overflow, item[64]);
               end
               seen = 0;
            end else begin
               prev_stall = 1;
               held_w = outw;
               held_o = overflow;
               held_p = pass_count;
            end
         end
      end
   end

   // random out_ready
   initial begin
      forever begin
         @(posedge clk); #1;
         if (rand_rdy) out_ready = 1'($urandom_range(0, 1));
      end
   end

   initial begin
      int            acc;
      int            hs;
      int            n;
      logic [4*IB-1:0] v;
      logic [65:0]   tot;

      rst_n     = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      for (int i = 0; i < NW; i++) in_words[i] = '0;
      repeat (2) @(posedge clk);
      #1;
      chk("reset_in_ready", in_ready, 1);
      chk("reset_out_valid", out_valid, 0);
      chk("reset_overflow", overflow, 0);
      chk("reset_pass_count", pass_count, 0);
      chk("reset_out_words", outw, 0);
      chk("reset_state", state_dbg, IDLE);
      rst_n = 1'b1;
      @(posedge clk); #1;

      // canonical, carry ripple, top overflow
      send({17'h0, 17'h0, 17'h05678, 17'h01234}, 64'h0000_0000_5678_1234, 1'b0, 8'd0, 1, acc);
      send({17'h0, 17'h0FFFF, 17'h0FFFF, 17'h1FFFF}, 64'h0001_0000_0000_FFFF, 1'b0, 8'd3, 1, acc);
      send({17'h10000, 17'h0, 17'h0, 17'h0}, 64'h0, 1'b1, 8'd1, 1, acc);

      // backpressure with a new product waiting
      n = 0;
      while (exp_q.size() != 0 && n < 50) begin @(posedge clk); #1; n++; end
      out_ready = 1'b0;
      send({17'h0, 17'h0, 17'h10001, 17'h10002}, 64'h0000_0001_0002_0002, 1'b0, 8'd1, 1, acc);
      n = 0;
      while (!out_valid && n < 50) begin @(posedge clk); #1; n++; end
      chk("bp_reach_done", out_valid, 1);
      in_valid    = 1'b1;
      in_words[0] = 17'h00011;
      in_words[1] = 17'h00042;
      in_words[2] = 17'h0;
      in_words[3] = 17'h0;
      repeat (5) begin
         @(negedge clk);
         chk("bp_in_ready", in_ready, 0);
         chk("bp_state", state_dbg, DONE);
      end
      @(posedge clk); #1;
      out_ready = 1'b1;
      @(posedge clk); #1;
      chk("bp_idle_after_hs", state_dbg, IDLE);
      hs = cyc;
      send({17'h0, 17'h0, 17'h00042, 17'h00011}, 64'h0000_0000_0042_0011, 1'b0, 8'd0, 1, acc);
      chk("bp_accept_delay", 64'(acc - hs), 1);

      // reset during pass 2 of the ripple case
      n = 0;
      while (exp_q.size() != 0 && n < 50) begin @(posedge clk); #1; n++; end
      send({17'h0, 17'h0FFFF, 17'h0FFFF, 17'h1FFFF}, 64'h0, 1'b0, 8'd0, 0, acc);
      @(posedge clk); #1;
      rst_n = 1'b0;
      @(posedge clk); #1;
      chk("mid_reset_state", state_dbg, IDLE);
      chk("mid_reset_in_ready", in_ready, 1);
      chk("mid_reset_out_valid", out_valid, 0);
      chk("mid_reset_overflow", overflow, 0);
      chk("mid_reset_pass_count", pass_count, 0);
      rst_n = 1'b1;
      @(posedge clk); #1;
      send({17'h0, 17'h0, 17'h0BEEF, 17'h0CAFE}, 64'h0000_0000_BEEF_CAFE, 1'b0, 8'd0, 1, acc);

      // random back-to-back with random out_ready
      rand_rdy = 1;
      for (int k = 0; k < 200; k++) begin
         tot = '0;
         for (int i = 0; i < NW; i++) begin
            v[IB*i +: IB] = IB'($urandom_range(0, 32'h1FFFF));
            tot = tot + (66'(v[IB*i +: IB]) << (WL * i));
         end
         send(v, tot[63:0], |tot[65:64], 8'hFF, 1, acc);
      end
      rand_rdy  = 0;
      out_ready = 1'b1;

      n = 0;
      while (exp_q.size() != 0 && n < 500) begin @(posedge clk); #1; n++; end
      chk("queue_drained", exp_q.size(), 0);
      repeat (2) @(posedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule
